// File: rtl/systolic_feeder.sv
// Operand store and skewed stream generator for a 3x3 output-stationary systolic multiplier.
// One clear cycle precedes a 7-cycle feed; done pulses once when all nine accumulators are final.
module systolic_feeder #(
    parameter int DW       = 4,
    parameter int FEED_LEN = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [3:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          arr_rst,
    output logic [DW-1:0] h1,
    output logic [DW-1:0] h2,
    output logic [DW-1:0] h3,
    output logic [DW-1:0] v1,
    output logic [DW-1:0] v2,
    output logic [DW-1:0] v3,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_FEED  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [2:0] T_LAST  = 3'(FEED_LEN - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    t_q, t_d;
    logic [DW-1:0] a_q [9];
    logic [DW-1:0] a_d [9];
    logic [DW-1:0] b_q [9];
    logic [DW-1:0] b_d [9];
    logic [DW-1:0] h_s [3];
    logic [DW-1:0] v_s [3];
    logic          ld_ok;

    // Storage is writable only while the array is not consuming it.
    assign ld_ok = ld_en && (ld_addr <= 4'd8) && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = 3'd0;
            end
            S_FEED: begin
                if (t_q == T_LAST) begin
                    state_d = S_DONE;
                    t_d     = 3'd0;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            default: begin
                state_d = start ? S_CLEAR : S_IDLE;
            end
        endcase
        if (ld_ok) begin
            if (ld_sel) b_d[ld_addr] = ld_data;
            else        a_d[ld_addr] = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_q     <= 3'd0;
            for (int i = 0; i < 9; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < 9; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

    // Row/column r lags by r cycles; element k = t - r is valid for 0..2.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            h_s[r] = '0;
            v_s[r] = '0;
            if (state_q == S_FEED && int'(t_q) >= r && int'(t_q) - r <= 2) begin
                h_s[r] = a_q[r * 3 + int'(t_q) - r];
                v_s[r] = b_q[(int'(t_q) - r) * 3 + r];
            end
        end
    end

    assign h1      = h_s[0];
    assign h2      = h_s[1];
    assign h3      = h_s[2];
    assign v1      = v_s[0];
    assign v2      = v_s[1];
    assign v3      = v_s[2];
    assign arr_rst = !rst || (state_q == S_CLEAR);
    assign busy    = (state_q == S_CLEAR) || (state_q == S_FEED);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: drives a behavioural 3x3 systolic array from the
// feeder streams and checks stream skew, control timing and the resulting products.
module tb_systolic_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en, ld_sel, start;
    logic [3:0] ld_addr, ld_data;
    logic       arr_rst, busy, done;
    logic [3:0] h1, h2, h3, v1, v2, v3;

    int checks   = 0;
    int failures = 0;

    systolic_feeder dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .arr_rst(arr_rst),
        .h1(h1), .h2(h2), .h3(h3), .v1(v1), .v2(v2), .v3(v3),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array fed by the DUT streams.
    logic [3:0] hs [3];
    logic [3:0] vs [3];
    logic [3:0] hp [3][3];
    logic [3:0] vp [3][3];
    logic [7:0] acc [3][3];
    int         done_cnt = 0;

    assign hs[0] = h1; assign hs[1] = h2; assign hs[2] = h3;
    assign vs[0] = v1; assign vs[1] = v2; assign vs[2] = v3;

    always @(posedge clk) begin
        logic [3:0] hin, vin;
        if (done) done_cnt <= done_cnt + 1;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                hin = (j == 0) ? hs[i] : hp[i][j-1];
                vin = (i == 0) ? vs[j] : vp[i-1][j];
                if (arr_rst) begin
                    acc[i][j] <= 8'd0;
                    hp[i][j]  <= 4'd0;
                    vp[i][j]  <= 4'd0;
                end else begin
                    acc[i][j] <= acc[i][j] + ({4'd0, hin} * {4'd0, vin});
                    hp[i][j]  <= hin;
                    vp[i][j]  <= vin;
                end
            end
        end
    end

    typedef struct {
        logic [3:0] h1, h2, h3, v1, v2, v3;
    } vec_t;
    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic sel, input int addr, input int data);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = 4'(addr);
        ld_data = 4'(data);
        step();
        ld_en   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 30) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, int'(done), 1);
    endtask

    task automatic run(input string name);
        int lat;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        chk({name, "_clear_arr_rst"}, int'(arr_rst), 1);
        chk({name, "_clear_busy"}, int'(busy), 1);
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, lat, 9);
        chk({name, "_busy_in_done"}, int'(busy), 0);
    endtask

    task automatic check_c(input string name, input int e [9]);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_C%0d%0d", name, i / 3 + 1, i % 3 + 1), int'(acc[i/3][i%3]), e[i]);
    endtask

    task automatic load_skew();
        for (int i = 0; i < 9; i++) begin
            load(1'b0, i, i + 1);
            load(1'b1, i, 9 - i);
        end
    endtask

    int e_id [9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int e_skew [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int e_ovf [9]  = '{163, 163, 163, 163, 163, 163, 163, 163, 163};
    int e_zero [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int dc;
        logic any_done;
        tbl[0] = '{4'd1, 4'd0, 4'd0, 4'd9, 4'd0, 4'd0};
        tbl[1] = '{4'd2, 4'd4, 4'd0, 4'd6, 4'd8, 4'd0};
        tbl[2] = '{4'd3, 4'd5, 4'd7, 4'd3, 4'd5, 4'd7};
        tbl[3] = '{4'd0, 4'd6, 4'd8, 4'd0, 4'd2, 4'd4};
        tbl[4] = '{4'd0, 4'd0, 4'd9, 4'd0, 4'd0, 4'd1};
        tbl[5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        tbl[6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

        rst = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 4'd0; start = 1'b0;
        step(); step();
        chk("rst_arr_rst", int'(arr_rst), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_h1", int'(h1), 0);
        rst = 1'b1;
        step();
        chk("rel_arr_rst", int'(arr_rst), 0);
        chk("rel_busy", int'(busy), 0);

        // Identity A, B = 1..9; out-of-range addresses must not alias into storage.
        for (int i = 0; i < 9; i++) begin
            load(1'b0, i, (i % 4 == 0) ? 1 : 0);
            load(1'b1, i, i + 1);
        end
        for (int i = 9; i < 16; i++) begin
            load(1'b0, i, 15);
            load(1'b1, i, 15);
        end
        run("ident");
        check_c("ident", e_id);
        step();
        chk("ident_done_pulse", int'(done), 0);

        // Skew trace with A = 1..9, B = 9..1.
        load_skew();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("skew_clear", int'(arr_rst), 1);
        step();
        for (int t = 0; t < 7; t++) begin
            chk($sformatf("skew_t%0d_h1", t), int'(h1), int'(tbl[t].h1));
            chk($sformatf("skew_t%0d_h2", t), int'(h2), int'(tbl[t].h2));
            chk($sformatf("skew_t%0d_h3", t), int'(h3), int'(tbl[t].h3));
            chk($sformatf("skew_t%0d_v1", t), int'(v1), int'(tbl[t].v1));
            chk($sformatf("skew_t%0d_v2", t), int'(v2), int'(tbl[t].v2));
            chk($sformatf("skew_t%0d_v3", t), int'(v3), int'(tbl[t].v3));
            chk($sformatf("skew_t%0d_busy", t), int'(busy), 1);
            chk($sformatf("skew_t%0d_arr_rst", t), int'(arr_rst), 0);
            step();
        end
        chk("skew_done", int'(done), 1);
        chk("skew_done_h3", int'(h3), 0);
        check_c("skew", e_skew);
        step();

        // Overflow: all 15; final B write coincides with start.
        for (int i = 0; i < 9; i++) load(1'b0, i, 15);
        for (int i = 0; i < 8; i++) load(1'b1, i, 15);
        ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 4'd8; ld_data = 4'd15; start = 1'b1;
        step();
        ld_en = 1'b0; start = 1'b0;
        step();
        // Mid-FEED write and start must both be ignored.
        ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd4; ld_data = 4'd5; start = 1'b1;
        step();
        ld_en = 1'b0; start = 1'b0;
        chk("feed_start_ignored_busy", int'(busy), 1);
        dc = done_cnt;
        wait_done("ovf");
        check_c("ovf", e_ovf);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_arr_rst", int'(arr_rst), 1);
        chk("b2b_done_low", int'(done), 0);
        wait_done("b2b");
        check_c("b2b", e_ovf);
        step();
        chk("b2b_idle", int'(busy), 0);
        chk("ovf_done_count", done_cnt - dc, 2);

        // Abort at t=3, then run without reloading (storage cleared) and with reload.
        load_skew();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        chk("abort_pre_h2", int'(h2), 6);
        dc = done_cnt;
        rst = 1'b0;
        #1;
        chk("abort_arr_rst", int'(arr_rst), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_h2", int'(h2), 0);
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || busy) any_done = 1'b1;
        end
        chk("abort_quiet", int'(any_done), 0);
        rst = 1'b1;
        step();
        step();
        chk("abort_no_stale_done", done_cnt - dc, 0);
        run("cleared");
        check_c("cleared", e_zero);
        step();
        load_skew();
        run("reload");
        check_c("reload", e_skew);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream controller for the 3x3 output-stationary systolic multiplier array with 4-bit operands, 8-bit accumulators and synchronous active-high array reset.
- Stores operand matrices A and B, issues one clear cycle to the array, then drives skewed row streams h1..h3 and column streams v1..v3 so every PE(i,j) accumulates sum_k A[i][k]*B[k][j].
- Signals completion when all nine array accumulators hold final products.

Parameters:
- DW, 4, operand element width; must match array input width.
- FEED_LEN, 7, feed-phase cycles (N + 2*(N-1) for N=3); fixed, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_en  in  1  write-enable for matrix storage.
- ld_sel  in  1  0 = write A, 1 = write B.
- ld_addr  in  4  element index, row-major, 0..8 (row = addr/3, col = addr%3).
- ld_data  in  DW  element value.
- start  in  1  begin a multiply.
- arr_rst  out  1  synchronous active-high clear to the array.
- h1, h2, h3  out  DW  row streams into array columns-left edge.
- v1, v2, v3  out  DW  column streams into array top edge.
- busy  out  1  high in CLEAR and FEED.
- done  out  1  one-cycle pulse; array results valid.

Behaviour:
- States: IDLE, CLEAR, FEED, DONE. A 3-bit feed counter t runs 0..6.
- Async reset (rst=0) forces IDLE and t=0, clears all 18 matrix registers, and drives h*/v* = 0, busy = 0, done = 0, arr_rst = 1.
- Releasing rst returns to IDLE with arr_rst=0.
- IDLE:
  - start=1 at an edge -> CLEAR.
  - ld_en writes storage at the edge.
- CLEAR: exactly one cycle; arr_rst=1, h*/v*=0, busy=1; -> FEED with t=0.
- FEED: busy=1, arr_rst=0; t increments each edge; t=6 -> DONE.
- Stream values in FEED at counter t, 1-based i,j, k = t-(i-1) for rows and k = t-(j-1) for columns:
  - h_i = A[i-1][k] when 0<=k<=2, else 0.
  - v_j = B[k][j-1] when 0<=k<=2, else 0.
- Outputs h*, v*, arr_rst, busy and done decode directly from the registered state, t and storage, with no extra pipeline stage.
- DONE: one cycle; done=1, busy=0, h*/v*=0; -> IDLE.
  - start=1 in DONE -> CLEAR, i.e. back-to-back operation.
  - The last accumulation (PE33, k=2, t=6) lands at the edge ending FEED, so all C outputs are final in the DONE cycle.
- Latency: start sampled at edge E0 -> done high in the 9th cycle after E0 (1 CLEAR + 7 FEED + DONE).
- Load rules:
  - ld_en is honoured only in IDLE or DONE; it is ignored in CLEAR and FEED, so operands stay stable mid-run.
  - ld_addr > 8 is ignored.
  - ld_en and start in the same IDLE edge: the write completes and the run uses the new value, because feed begins two cycles later.
- start while busy is ignored; no queuing.
- Reset mid-FEED aborts immediately. arr_rst=1 clears the array, and no done is produced.
- Arithmetic belongs to the array: 8-bit accumulators wrap modulo 256. The feeder does no width checks.
- Outside FEED, h*/v* are always 0, so an idle array accumulates nothing.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-stream -> arr_rst=1, all h*/v*=0, busy=0, done=0; reading back through a run gives C=0.
- Identity: A=I, B=[1..9] row-major, start -> done 9 cycles after start edge. Array C011..C033 = 1,2,3,4,5,6,7,8,9.
- Skew check: A=[1..9], B=[9..1], trace FEED:
  - t=0: h1=1, h2=0, v1=9, v2=0.
  - t=2: h3=7, v3=7.
  - t=6: all zero.
  - Result C011=30, C022=69, C033=90.
- Overflow: A and B all 15 -> every C = 675 mod 256 = 163. done pulses once.
- Protocol:
  - ld_en with addr=4, data=5 during FEED -> stored value unchanged.
  - start during FEED ignored.
  - start in DONE -> arr_rst=1 the next cycle, and second-run results are not accumulated onto the first.
- Abort: rst=0 at t=3 then release, reload and run -> correct results, no stale done.
